// File: rtl/bsg_sync_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bsg_sync_hs_pkg
// Brief   : Shared types and 4-phase handshake constants for the synchronous
//           handshake CDC controllers (rx today, tx later).
// Revision: 1.0 - initial release
// ============================================================================
package bsg_sync_hs_pkg;

  // Receive controller states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } bsg_sync_hs_rx_state_e;

  // Number of flops the request passes through before the FSM looks at it.
  localparam int c_sync_stages = 2;

  // 4-phase protocol levels. Request and ack both idle low; a transfer is
  // req up, ack up, req down, ack down.
  localparam logic c_req_active = 1'b1;
  localparam logic c_req_idle   = 1'b0;
  localparam logic c_ack_active = 1'b1;
  localparam logic c_ack_idle   = 1'b0;

  // True when the synchronized request shows the sender has released it.
  function automatic logic hs_req_released(input logic req_s);
    return (req_s == c_req_idle);
  endfunction

  // True when the synchronized request shows a word is being offered.
  function automatic logic hs_req_offered(input logic req_s);
    return (req_s == c_req_active);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_sync_hs_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : bsg_sync_hs_rx_ctrl_if
// Brief   : Bundle of the sender-side (req/data/ack) and consumer-side
//           (data/v/yumi) handshake signals of the receive controller.
//           Signal suffixes are relative to the controller.
// Revision: 1.0 - initial release
// ============================================================================
interface bsg_sync_hs_rx_ctrl_if #(
  parameter int width_p = 16
);

  // Sender side (asynchronous to the receive clock)
  logic               iclk_req_i;
  logic [width_p-1:0] iclk_data_i;
  logic               ack_o;

  // Consumer side (receive clock domain)
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               yumi_i;

  // Environment: drives the sender and consumer, observes the controller.
  modport master (
    output iclk_req_i,
    output iclk_data_i,
    output yumi_i,
    input  ack_o,
    input  data_o,
    input  v_o
  );

  // Controller view.
  modport slave (
    input  iclk_req_i,
    input  iclk_data_i,
    input  yumi_i,
    output ack_o,
    output data_o,
    output v_o
  );

endinterface
`default_nettype wire

// File: rtl/bsg_sync_sync.sv
`default_nettype none
// ============================================================================
// Module  : bsg_sync_sync
// Brief   : Two-flop synchronizer bringing an asynchronous level into the
//           oclk_i domain. No reset: the chain flushes itself within two
//           cycles, and resetting it would only add a reset path to the
//           metastability-sensitive first stage.
// Revision: 1.0 - initial release
// ============================================================================
module bsg_sync_sync #(
  parameter int width_p = 1
) (
  input  logic               oclk_i,
  input  logic [width_p-1:0] iclk_data_i,
  output logic [width_p-1:0] oclk_data_o
);

  logic [width_p-1:0] r_sync_meta;
  logic [width_p-1:0] r_sync_out;

  // Two back-to-back flops; the first may go metastable, the second settles.
  always_ff @(posedge oclk_i) begin
    r_sync_meta <= iclk_data_i;
    r_sync_out  <= r_sync_meta;
  end

  assign oclk_data_o = r_sync_out;

endmodule
`default_nettype wire

// File: rtl/bsg_sync_hs_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bsg_sync_hs_rx_ctrl
// Brief   : Receive-side controller for a 4-phase bundled-data clock-domain
//           crossing. Only the request is synchronized; the data word is
//           captured once the synchronized request is seen, relying on the
//           sender to hold it stable while req is high. The word is offered
//           on valid/yumi and a glitch-free registered ack is returned.
// Revision: 1.0 - initial release
// ============================================================================
module bsg_sync_hs_rx_ctrl
  import bsg_sync_hs_pkg::*;
#(
  parameter int width_p       = 16,
  parameter int count_width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bsg_sync_hs_rx_ctrl_if.slave     bus,
  output logic                     err_o,
  output logic [count_width_p-1:0] count_o
);

  // --------------------------------------------------------------------------
  // Request synchronizer
  // --------------------------------------------------------------------------
  logic w_req_s;

  bsg_sync_sync #(
    .width_p (1)
  ) u_req_sync (
    .oclk_i      (clk_i),
    .iclk_data_i (bus.iclk_req_i),
    .oclk_data_o (w_req_s)
  );

  // --------------------------------------------------------------------------
  // Controller FSM
  // --------------------------------------------------------------------------
  bsg_sync_hs_rx_state_e r_state;
  bsg_sync_hs_rx_state_e w_state_n;

  logic w_capture;   // latch the bundled word this cycle
  logic w_take;      // consumer accepted the word this cycle
  logic w_err_set;   // sender released req before we acked

  // Next-state and per-cycle strobes. yumi is only honoured in VALID, so a
  // stray yumi elsewhere changes nothing.
  always_comb begin
    w_state_n = r_state;
    w_capture = 1'b0;
    w_take    = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        // Leaving ACK required req_s low, so any high seen here is a fresh
        // request edge (or a sender still waiting after a reset).
        if (hs_req_offered(w_req_s)) begin
          w_capture = 1'b1;
          w_state_n = VALID;
        end
      end
      VALID: begin
        if (hs_req_released(w_req_s)) begin
          // Flag the violation but keep the word; it was already captured.
          w_err_set = 1'b1;
        end
        if (bus.yumi_i) begin
          w_take    = 1'b1;
          w_state_n = ACK;
        end
      end
      ACK: begin
        if (hs_req_released(w_req_s)) begin
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // State register plus one-hot decoded output flops, so v_o and ack_o come
  // straight from a flop and cannot glitch on multi-bit state changes.
  logic r_v;
  logic r_ack;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_v     <= 1'b0;
      r_ack   <= c_ack_idle;
    end else begin
      r_state <= w_state_n;
      r_v     <= (w_state_n == VALID);
      r_ack   <= (w_state_n == ACK) ? c_ack_active : c_ack_idle;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: captured word, transfer counter, sticky error
  // --------------------------------------------------------------------------
  logic [width_p-1:0]       r_data;
  logic [count_width_p-1:0] r_count;
  logic                     r_err;

  // Data register only loads on capture, so data_o holds between transfers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= bus.iclk_data_i;
    end
  end

  // Completed-transfer counter; wraps naturally at 2^count_width_p.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (w_take) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Protocol-violation flag; once set it stays set until reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.data_o = r_data;
  assign bus.v_o    = r_v;
  assign bus.ack_o  = r_ack;
  assign err_o      = r_err;
  assign count_o    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bsg_sync_hs_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsg_sync_hs_rx_ctrl
// Brief   : Directed self-checking bench for bsg_sync_hs_rx_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bsg_sync_hs_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       err;
  logic [7:0] count;

  int n_checks = 0;
  int n_errors = 0;

  bsg_sync_hs_rx_ctrl_if #(.width_p(16)) bus ();

  bsg_sync_hs_rx_ctrl #(
    .width_p       (16),
    .count_width_p (8)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus),
    .err_o   (err),
    .count_o (count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_v(input logic val, input int limit, input string tag);
    int k = 0;
    while (bus.v_o !== val && k < limit) begin
      tick();
      k++;
    end
    chk(tag, 32'(bus.v_o), 32'(val));
  endtask

  task automatic wait_ack(input logic val, input int limit, input string tag);
    int k = 0;
    while (bus.ack_o !== val && k < limit) begin
      tick();
      k++;
    end
    chk(tag, 32'(bus.ack_o), 32'(val));
  endtask

  logic [15:0] word;
  int          stall;

  initial begin
    reset           = 1'b1;
    bus.iclk_req_i  = 1'b0;
    bus.iclk_data_i = 16'h0000;
    bus.yumi_i      = 1'b0;
    tick(4);

    // ---- reset state
    chk("rst_v",     32'(bus.v_o),    32'h0);
    chk("rst_ack",   32'(bus.ack_o),  32'h0);
    chk("rst_err",   32'(err),        32'h0);
    chk("rst_count", 32'(count),      32'h0);
    chk("rst_data",  32'(bus.data_o), 32'h0);
    reset = 1'b0;
    tick(2);

    // ---- 1: single transfer with exact latencies
    bus.iclk_data_i = 16'hA5C3;
    bus.iclk_req_i  = 1'b1;
    tick();
    chk("t1_v_e1", 32'(bus.v_o), 32'h0);
    tick();
    chk("t1_v_e2", 32'(bus.v_o), 32'h0);
    tick();
    chk("t1_v_e3",  32'(bus.v_o),    32'h1);
    chk("t1_data",  32'(bus.data_o), 32'hA5C3);
    chk("t1_ack0",  32'(bus.ack_o),  32'h0);
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t1_ack1",  32'(bus.ack_o), 32'h1);
    chk("t1_v_off", 32'(bus.v_o),   32'h0);
    chk("t1_count", 32'(count),     32'h1);
    bus.iclk_req_i = 1'b0;
    tick(2);
    chk("t1_ack_hold", 32'(bus.ack_o), 32'h1);
    tick();
    chk("t1_ack_fall", 32'(bus.ack_o), 32'h0);
    chk("t1_err",      32'(err),       32'h0);
    tick(2);

    // ---- 4: stray yumi in IDLE and in ACK (illegal; must be ignored)
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t4_idle_count", 32'(count), 32'h1);
    chk("t4_idle_err",   32'(err),   32'h0);
    chk("t4_idle_v",     32'(bus.v_o), 32'h0);
    tick();
    chk("t4_idle_v2",    32'(bus.v_o), 32'h0);
    bus.iclk_data_i = 16'h1234;
    bus.iclk_req_i  = 1'b1;
    wait_v(1'b1, 10, "t4_v");
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t4_ack_count", 32'(count), 32'h2);
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t4_ack_count2", 32'(count),     32'h2);
    chk("t4_ack_hold",   32'(bus.ack_o), 32'h1);
    chk("t4_ack_v",      32'(bus.v_o),   32'h0);
    chk("t4_ack_err",    32'(err),       32'h0);
    bus.iclk_req_i = 1'b0;
    wait_ack(1'b0, 10, "t4_ack_low");

    // ---- 2: 300 back-to-back transfers with random consumer stall
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      word = 16'(i * 40503 + 17);
      bus.iclk_data_i = word;
      bus.iclk_req_i  = 1'b1;
      wait_v(1'b1, 10, "t2_v");
      stall = int'($urandom_range(0, 5));
      if (stall > 0) tick(stall);
      chk("t2_v_stall", 32'(bus.v_o),    32'h1);
      chk("t2_data",    32'(bus.data_o), 32'(word));
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
      chk("t2_ack", 32'(bus.ack_o), 32'h1);
      bus.iclk_req_i = 1'b0;
      wait_ack(1'b0, 10, "t2_ack_low");
    end
    chk("t2_count", 32'(count), 32'd44);
    chk("t2_err",   32'(err),   32'h0);

    // ---- 3: sender drops req early while yumi is withheld
    bus.iclk_data_i = 16'h3C3C;
    bus.iclk_req_i  = 1'b1;
    wait_v(1'b1, 10, "t3_v");
    bus.iclk_req_i = 1'b0;
    tick(2);
    chk("t3_err_pre", 32'(err), 32'h0);
    tick();
    chk("t3_err",  32'(err),        32'h1);
    chk("t3_v",    32'(bus.v_o),    32'h1);
    chk("t3_data", 32'(bus.data_o), 32'h3C3C);
    tick();
    chk("t3_v_hold", 32'(bus.v_o), 32'h1);
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t3_ack",   32'(bus.ack_o), 32'h1);
    chk("t3_count", 32'(count),     32'd45);
    tick();
    chk("t3_ack_fall", 32'(bus.ack_o), 32'h0);
    chk("t3_idle_v",   32'(bus.v_o),   32'h0);
    chk("t3_sticky",   32'(err),       32'h1);
    tick(2);
    chk("t3_sticky2",  32'(err),       32'h1);

    // ---- 5: reset while in ACK with req still high
    bus.iclk_data_i = 16'h5A5A;
    bus.iclk_req_i  = 1'b1;
    wait_v(1'b1, 10, "t5_v");
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t5_ack_pre", 32'(bus.ack_o), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ack_rst",   32'(bus.ack_o),  32'h0);
    chk("t5_v_rst",     32'(bus.v_o),    32'h0);
    chk("t5_count_rst", 32'(count),      32'h0);
    chk("t5_err_rst",   32'(err),        32'h0);
    chk("t5_data_rst",  32'(bus.data_o), 32'h0);
    wait_v(1'b1, 3, "t5_recapture");
    chk("t5_data", 32'(bus.data_o), 32'h5A5A);
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t5_ack",   32'(bus.ack_o), 32'h1);
    chk("t5_count", 32'(count),     32'h1);
    bus.iclk_req_i = 1'b0;
    wait_ack(1'b0, 10, "t5_ack_low");
    tick(2);

    // ---- 6: yumi in the same cycle req_s falls
    bus.iclk_data_i = 16'h6E6E;
    bus.iclk_req_i  = 1'b1;
    wait_v(1'b1, 10, "t6_v");
    bus.iclk_req_i = 1'b0;
    tick(2);
    chk("t6_err_pre", 32'(err),     32'h0);
    chk("t6_v_pre",   32'(bus.v_o), 32'h1);
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("t6_err",   32'(err),       32'h1);
    chk("t6_ack",   32'(bus.ack_o), 32'h1);
    chk("t6_v",     32'(bus.v_o),   32'h0);
    chk("t6_count", 32'(count),     32'h2);
    tick();
    chk("t6_ack_fall", 32'(bus.ack_o), 32'h0);
    tick();
    chk("t6_ack_stay", 32'(bus.ack_o), 32'h0);
    chk("t6_v_idle",   32'(bus.v_o),   32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
